// File: rtl/pc_adder_muxes.sv
// pc_adder_muxes
//   Program-counter datapath slice. Holds the PC register and forms the
//   next-PC value from one of three candidates:
//     seq = PC + INC                      (sequential fetch)
//     brz = PC + SEIMM                    (branch-if-zero taken)
//     jmp = {PC[WIDTH-1:JBITS], IR[JBITS-1:0]}  (pseudo-direct jump)
//   Select priority is jump, then branch, then sequential.
//
// Ports
//   CLK       in   1      system clock, rising edge
//   RESET     in   1      asynchronous reset, active low (clears PC)
//   PCWRT     in   1      PC load enable
//   SEIMM     in   WIDTH  sign-extended branch offset
//   IR        in   WIDTH  instruction word, low JBITS bits are the jump field
//   CTRLBRIZ  in   1      branch-taken select
//   CTRLJUMP  in   1      jump select (wins over CTRLBRIZ)
//   PC_IN     out  WIDTH  next-PC value, combinational
module pc_adder_muxes #(
    parameter int WIDTH = 16,
    parameter int INC   = 2,
    parameter int JBITS = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PCWRT,
    input  logic [WIDTH-1:0] SEIMM,
    input  logic [WIDTH-1:0] IR,
    input  logic             CTRLBRIZ,
    input  logic             CTRLJUMP,
    output logic [WIDTH-1:0] PC_IN
);

    localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] seq_target;
    logic [WIDTH-1:0] brz_target;
    logic [WIDTH-1:0] jmp_target;

    // High IR bits play no part in the jump target; they are tied off here
    // so the input stays fully consumed.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[WIDTH-1:JBITS];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc <= '0;
        end else if (PCWRT) begin
            pc <= PC_IN;
        end
    end

    // All additions wrap modulo 2^WIDTH; carries are dropped on purpose.
    assign seq_target = pc + INC_V;
    assign brz_target = pc + SEIMM;
    assign jmp_target = {pc[WIDTH-1:JBITS], IR[JBITS-1:0]};

    always_comb begin
        PC_IN = seq_target;
        if (CTRLJUMP) begin
            PC_IN = jmp_target;
        end else if (CTRLBRIZ) begin
            PC_IN = brz_target;
        end
    end

endmodule

// File: tb/tb_pc_adder_muxes.sv
module tb_pc_adder_muxes;

    logic        CLK;
    logic        RESET;
    logic        PCWRT;
    logic [15:0] SEIMM;
    logic [15:0] IR;
    logic        CTRLBRIZ;
    logic        CTRLJUMP;
    logic [15:0] PC_IN;

    int n_checks = 0;
    int n_fail   = 0;

    pc_adder_muxes #(.WIDTH(16), .INC(2), .JBITS(12)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PCWRT    (PCWRT),
        .SEIMM    (SEIMM),
        .IR       (IR),
        .CTRLBRIZ (CTRLBRIZ),
        .CTRLJUMP (CTRLJUMP),
        .PC_IN    (PC_IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wrt;
        logic        brz;
        logic        jmp;
        logic [15:0] seimm;
        logic [15:0] ir;
        logic [15:0] exp_pc_in;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic drive(input logic wrt, input logic brz, input logic jmp,
                         input logic [15:0] seimm, input logic [15:0] ir);
        PCWRT    = wrt;
        CTRLBRIZ = brz;
        CTRLJUMP = jmp;
        SEIMM    = seimm;
        IR       = ir;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Vectors applied back-to-back; PC evolves from 0x0000 after reset.
        //          wrt   brz   jmp   seimm     ir        pc_in
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002}; // hold, PC=0
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002}; // -> 0x0002
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0004}; // -> 0x0004
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0104}; // -> 0x0104
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0204}; // -> 0x0204
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'd70,   16'h0046}; // -> 0x0046
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'd70,   16'h0048}; // -> 0x0048
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0123, 16'h0123}; // jump wins, hold
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0123, 16'h004A}; // PC held at 0x48
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'hFFB6, 16'h0000, 16'hFFFE}; // -> 0xFFFE
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000}; // seq wraps
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0456, 16'hF456}; // keeps PC[15:12]
        vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000}; // -> 0x0000
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0010}; // -> 0x0010
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'hFFF0, 16'h0000, 16'h0000}; // negative offset
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16'hA113, 16'h0000, 16'hA123}; // -> 0xA123
        vecs[16] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0456, 16'hA456}; // -> 0xA456
        vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hF7FF, 16'hA7FF}; // IR[15:12] ignored
        vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA801}; // PC=0xA7FF

        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        check("reset_pc_in", PC_IN, 16'h0002);
        check("reset_pc", dut.pc, 16'h0000);

        // Reset held across a rising edge with PCWRT=1 must keep PC at zero.
        @(negedge CLK);
        PCWRT = 1'b1;
        @(negedge CLK);
        #1;
        check("reset_held_pc_in", PC_IN, 16'h0002);
        PCWRT = 1'b0;
        RESET = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            drive(vecs[i].wrt, vecs[i].brz, vecs[i].jmp, vecs[i].seimm, vecs[i].ir);
            #1;
            check($sformatf("vec%0d_pc_in", i), PC_IN, vecs[i].exp_pc_in);
        end

        // Mid-cycle reset: bring PC to 0x0104, then reset between edges.
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h0104, 16'h0000);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("pre_reset_pc_in", PC_IN, 16'h0106);
        #1;
        RESET = 1'b0;
        #1;
        check("async_reset_pc_in", PC_IN, 16'h0002);
        check("async_reset_pc", dut.pc, 16'h0000);
        @(negedge CLK);
        RESET = 1'b1;
        PCWRT = 1'b1;
        @(negedge CLK);
        #1;
        check("post_reset_first_load", PC_IN, 16'h0004);
        PCWRT = 1'b0;
        @(negedge CLK);
        #1;
        check("post_reset_hold", PC_IN, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
